spi_slave: RTL and testbench



---
 rtl/spi_slave.sv | 143 ++++++++++++++
 tb/tb_spi_slave.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, oversampled in the sclk domain.
// Ports: sclk/rst system side; txdata/tx_req load path; rxdata/rx_valid
// receive path; frame_err/busy status; spi_clk/spi_cs/spi_di/spi_do/
// spi_do_oe pin side (spi_do_oe mirrors busy).
module spi_slave #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] txdata,
    output logic             tx_req,
    output logic [WIDTH-1:0] rxdata,
    output logic             rx_valid,
    output logic             frame_err,
    output logic             busy,
    input  logic             spi_clk,
    input  logic             spi_cs,
    input  logic             spi_di,
    output logic             spi_do,
    output logic             spi_do_oe
);

    localparam int CW = $clog2(WIDTH);
    localparam int FW = $clog2(SYNC_STAGES + 2);
    localparam logic [FW-1:0] FILL_DONE = FW'(SYNC_STAGES + 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] di_sync;
    logic                   clk_hist;
    logic                   cs_hist;

    logic clk_s, cs_s, di_s;
    logic clk_rise, clk_fall, cs_rise, cs_fall;

    state_t         state;
    logic [CW-1:0]  bitcnt;
    logic [WIDTH-2:0] rx_sr;
    logic [WIDTH-1:0] rx_next;
    logic [WIDTH-1:0] tx_sr;
    logic [FW-1:0]  fill;

    always_ff @(posedge sclk) begin
        if (rst) begin
            clk_sync <= '0;
            cs_sync  <= '1;
            di_sync  <= '0;
            clk_hist <= 1'b0;
            cs_hist  <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            di_sync  <= {di_sync[SYNC_STAGES-2:0], spi_di};
            clk_hist <= clk_sync[SYNC_STAGES-1];
            cs_hist  <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign cs_s  = cs_sync[SYNC_STAGES-1];
    assign di_s  = di_sync[SYNC_STAGES-1];

    assign clk_rise = clk_s & ~clk_hist;
    assign clk_fall = ~clk_s & clk_hist;
    assign cs_rise  = cs_s & ~cs_hist;
    // The reset-time idle levels are still draining out of the
    // synchroniser until fill saturates; a CS that was already low
    // would otherwise look like a fresh falling edge.
    assign cs_fall  = ~cs_s & cs_hist & (fill == FILL_DONE);

    assign rx_next   = {rx_sr, di_s};
    assign spi_do_oe = busy;

    always_ff @(posedge sclk) begin
        if (rst) begin
            state     <= IDLE;
            bitcnt    <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            fill      <= '0;
            rxdata    <= '0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            spi_do    <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            frame_err <= 1'b0;
            if (fill != FILL_DONE) begin
                fill <= fill + FW'(1);
            end
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state  <= SHIFT;
                        busy   <= 1'b1;
                        bitcnt <= '0;
                        tx_sr  <= txdata;
                        spi_do <= txdata[WIDTH-1];
                        tx_req <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (bitcnt != '0) begin
                            frame_err <= 1'b1;
                        end
                    end else if (clk_rise) begin
                        rx_sr <= rx_next[WIDTH-2:0];
                        if (bitcnt == LAST_BIT) begin
                            bitcnt   <= '0;
                            rxdata   <= rx_next;
                            rx_valid <= 1'b1;
                            tx_sr    <= txdata;
                            tx_req   <= 1'b1;
                        end else begin
                            bitcnt <= bitcnt + CW'(1);
                        end
                    end else if (clk_fall) begin
                        // At a word boundary the new word is already
                        // in place; otherwise advance to the next bit.
                        if (bitcnt != '0) begin
                            tx_sr  <= {tx_sr[WIDTH-2:0], 1'b0};
                            spi_do <= tx_sr[WIDTH-2];
                        end else begin
                            spi_do <= tx_sr[WIDTH-1];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-banged mode-0 master at sclk/spi_clk = 8,
// vector table for single frames plus sequences for the corner cases.
module tb_spi_slave;

    logic       sclk;
    logic       rst;
    logic [7:0] txdata;
    logic       tx_req;
    logic [7:0] rxdata;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
    logic       spi_clk;
    logic       spi_cs;
    logic       spi_di;
    logic       spi_do;
    logic       spi_do_oe;

    spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .sclk      (sclk),
        .rst       (rst),
        .txdata    (txdata),
        .tx_req    (tx_req),
        .rxdata    (rxdata),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy),
        .spi_clk   (spi_clk),
        .spi_cs    (spi_cs),
        .spi_di    (spi_di),
        .spi_do    (spi_do),
        .spi_do_oe (spi_do_oe)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] tx;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int rxv_cnt = 0;
    int txr_cnt = 0;
    int ferr_cnt = 0;
    logic oe_seen = 1'b0;
    logic rxv_prev = 1'b0;
    logic txr_prev = 1'b0;
    logic ferr_prev = 1'b0;

    logic [7:0] sb[$];
    logic [7:0] tx_q[$];
    logic [7:0] mosi_q[$];
    logic [7:0] miso_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge sclk) begin
        check("oe_eq_busy", {31'd0, spi_do_oe}, {31'd0, busy});
        if (rx_valid) begin
            rxv_cnt++;
            check("rx_valid_pulse", {31'd0, rxv_prev}, 32'd0);
            if (sb.size() == 0) begin
                check("rx_unexpected", {24'd0, rxdata}, 32'hFFFF_FFFF);
            end else begin
                check("rxdata", {24'd0, rxdata}, {24'd0, sb.pop_front()});
            end
        end
        if (tx_req) begin
            txr_cnt++;
            check("tx_req_pulse", {31'd0, txr_prev}, 32'd0);
            if (tx_q.size() != 0) txdata = tx_q.pop_front();
        end
        if (frame_err) begin
            ferr_cnt++;
            check("frame_err_pulse", {31'd0, ferr_prev}, 32'd0);
        end
        if (spi_do_oe) oe_seen = 1'b1;
        rxv_prev  = rx_valid;
        txr_prev  = tx_req;
        ferr_prev = frame_err;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic send_bits(input logic [7:0] m, input int nbits,
                             output logic [7:0] r);
        r = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_di = m[7-i];
            wait_cyc(4);
            spi_clk = 1'b1;
            r[7-i] = spi_do;
            wait_cyc(4);
            spi_clk = 1'b0;
        end
    endtask

    task automatic run_frame();
        int n;
        int txr0;
        int rxv0;
        logic [7:0] m;
        logic [7:0] r;
        logic [7:0] e;
        n = mosi_q.size();
        txr0 = txr_cnt;
        rxv0 = rxv_cnt;
        spi_cs = 1'b0;
        wait_cyc(8);
        while (mosi_q.size() != 0) begin
            m = mosi_q.pop_front();
            e = miso_q.pop_front();
            sb.push_back(m);
            send_bits(m, 8, r);
            check("miso_word", {24'd0, r}, {24'd0, e});
        end
        wait_cyc(4);
        spi_cs = 1'b1;
        wait_cyc(12);
        check("sb_drained", sb.size(), 32'd0);
        check("tx_req_count", txr_cnt - txr0, n + 1);
        check("rx_valid_count", rxv_cnt - rxv0, n);
    endtask

    task automatic check_reset_outs(input string name);
        check(name, {rxdata, rx_valid, tx_req, frame_err, busy,
                     spi_do, spi_do_oe}, '0);
    endtask

    vec_t vecs[4];

    initial begin
        logic [7:0] prev;
        logic [7:0] r;
        int t0;
        int r0;
        int f0;

        vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[3] = '{8'h69, 8'hB2, 8'h69, 8'hB2};

        rst = 1'b1;
        spi_cs = 1'b1;
        spi_clk = 1'b0;
        spi_di = 1'b0;
        txdata = 8'h00;
        wait_cyc(3);
        check_reset_outs("reset_outputs");
        rst = 1'b0;
        wait_cyc(5);

        foreach (vecs[i]) begin
            txdata = vecs[i].tx;
            mosi_q.push_back(vecs[i].mosi);
            miso_q.push_back(vecs[i].exp_miso);
            run_frame();
            check("rxdata_after", {24'd0, rxdata}, {24'd0, vecs[i].exp_rx});
        end
        check("no_frame_err", ferr_cnt, 32'd0);

        txdata = 8'h80;
        tx_q.push_back(8'h7E);
        mosi_q.push_back(8'h01);
        mosi_q.push_back(8'hFF);
        miso_q.push_back(8'h80);
        miso_q.push_back(8'h7E);
        run_frame();

        prev = rxdata;
        f0 = ferr_cnt;
        r0 = rxv_cnt;
        txdata = 8'h55;
        spi_cs = 1'b0;
        wait_cyc(8);
        send_bits(8'hF0, 3, r);
        wait_cyc(4);
        spi_cs = 1'b1;
        wait_cyc(12);
        check("frame_err_count", ferr_cnt - f0, 32'd1);
        check("partial_no_rx", rxv_cnt - r0, 32'd0);
        check("partial_rxdata_hold", {24'd0, rxdata}, {24'd0, prev});
        txdata = 8'h96;
        mosi_q.push_back(8'h5A);
        miso_q.push_back(8'h96);
        run_frame();

        txdata = 8'h11;
        spi_cs = 1'b0;
        wait_cyc(8);
        send_bits(8'hAF, 4, r);
        rst = 1'b1;
        wait_cyc(2);
        check_reset_outs("reset_mid_frame");
        rst = 1'b0;
        f0 = ferr_cnt;
        r0 = rxv_cnt;
        t0 = txr_cnt;
        send_bits(8'hAF, 4, r);
        wait_cyc(6);
        check("low_cs_no_start", txr_cnt - t0, 32'd0);
        check("low_cs_not_busy", {31'd0, busy}, 32'd0);
        check("low_cs_no_rx", rxv_cnt - r0, 32'd0);
        check("reset_no_ferr", ferr_cnt - f0, 32'd0);
        spi_cs = 1'b1;
        wait_cyc(12);
        txdata = 8'h24;
        mosi_q.push_back(8'hC3);
        miso_q.push_back(8'h24);
        run_frame();

        oe_seen = 1'b0;
        t0 = txr_cnt;
        r0 = rxv_cnt;
        send_bits(8'hFF, 8, r);
        send_bits(8'hFF, 8, r);
        wait_cyc(8);
        check("idle_no_tx_req", txr_cnt - t0, 32'd0);
        check("idle_no_rx", rxv_cnt - r0, 32'd0);
        check("idle_oe_low", {31'd0, oe_seen}, 32'd0);

        txdata = 8'hFF;
        for (int i = 0; i <= 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            mosi_q.push_back(b);
            miso_q.push_back(~b);
            if (i > 0) tx_q.push_back(~b);
        end
        run_frame();
        check("loop_rxdata_wrap", {24'd0, rxdata}, 32'd0);
        check("total_frame_err", ferr_cnt, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
